pic_instr_sequencer: RTL

- Instruction-decode and Q-phase sequencing stage directly upstream of the ALU.
- Latches each 14-bit PIC16 instruction and generates a 4-phase (Q1–Q4) instruction cycle.
- Drives the ALU op/destination/write-enable controls, the file address, literal and bit select.
- Issues PC/stack controls and handles skip/branch flushes (2-cycle instructions).

---
 rtl/pic_instr_sequencer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/pic_instr_sequencer.sv
// pic_instr_sequencer: PIC16 instruction register, Q1-Q4 phase sequencing and decode to ALU/PC/stack controls
module pic_instr_sequencer #(
  parameter int PC_W    = 11,
  parameter int FADDR_W = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [13:0]        instr_in,
  input  logic               alu_out_z,
  input  logic               alu_bit_test_res,
  output logic [1:0]         q_phase,
  output logic [13:0]        ir,
  output logic [3:0]         alu_op,
  output logic               alu_d,
  output logic               alu_d_wr_en,
  output logic               alu_status_wr_en,
  output logic               lit_sel,
  output logic [7:0]         literal,
  output logic [FADDR_W-1:0] f_addr,
  output logic [2:0]         bit_sel,
  output logic               bit_set_en,
  output logic               bit_clr_en,
  output logic               pc_inc,
  output logic               pc_load,
  output logic [PC_W-1:0]    pc_load_val,
  output logic               stack_push,
  output logic               stack_pop,
  output logic               illegal_instr
);
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_IOR = 4'd3,
                         OP_XOR = 4'd4, OP_COM = 4'd5, OP_DEC = 4'd6, OP_INC = 4'd7,
                         OP_PLF = 4'd8, OP_PW = 4'd9, OP_RLF = 4'd10, OP_RRF = 4'd11,
                         OP_SWP = 4'd12, OP_CLR = 4'd13;
  localparam logic [1:0] Q1 = 2'd0, Q4 = 2'd3;
  logic [1:0]  q_q, q_d;
  logic [13:0] ir_q, ir_d;
  logic        flush_q, flush_d;
  logic [3:0]  op;
  logic        d, ls, bw, wr, st, skz, bset, bclr, btc, bts, push, pop, ld, fl, ill, q4;
  always_comb begin
    op = OP_ADD; d = 1'b0; ls = 1'b0; bw = 1'b0; wr = 1'b0; st = 1'b0; skz = 1'b0;
    bset = 1'b0; bclr = 1'b0; btc = 1'b0; bts = 1'b0; push = 1'b0; pop = 1'b0;
    ld = 1'b0; fl = 1'b0; ill = 1'b0;
    casez (ir_q[13:8])
      6'b000111: begin op = OP_ADD; bw = 1'b1; st = 1'b1; end
      6'b000101: begin op = OP_AND; bw = 1'b1; st = 1'b1; end
      6'b000010: begin op = OP_SUB; bw = 1'b1; st = 1'b1; end
      6'b000100: begin op = OP_IOR; bw = 1'b1; st = 1'b1; end
      6'b000110: begin op = OP_XOR; bw = 1'b1; st = 1'b1; end
      6'b001001: begin op = OP_COM; bw = 1'b1; st = 1'b1; end
      6'b000011: begin op = OP_DEC; bw = 1'b1; st = 1'b1; end
      6'b001010: begin op = OP_INC; bw = 1'b1; st = 1'b1; end
      6'b001000: begin op = OP_PLF; bw = 1'b1; st = 1'b1; end
      6'b001101: begin op = OP_RLF; bw = 1'b1; end
      6'b001100: begin op = OP_RRF; bw = 1'b1; end
      6'b001110: begin op = OP_SWP; bw = 1'b1; end
      6'b001011: begin op = OP_DEC; bw = 1'b1; skz = 1'b1; end
      6'b001111: begin op = OP_INC; bw = 1'b1; skz = 1'b1; end
      6'b000001: begin op = OP_CLR; d = ir_q[7]; wr = 1'b1; st = 1'b1; end
      6'b000000:
        if (ir_q[7]) begin
          op = OP_PW; d = 1'b1; wr = 1'b1;
        end else if (ir_q[6:0] == 7'h08 || ir_q[6:0] == 7'h09) begin
          pop = 1'b1; fl = 1'b1;
        end else begin
          ill = !(ir_q[6] == 1'b0 && ir_q[3:0] == 4'h0) && ir_q[6:0] != 7'h63 && ir_q[6:0] != 7'h64;
        end
      6'b0100??: bclr = 1'b1;
      6'b0101??: bset = 1'b1;
      6'b0110??: btc = 1'b1;
      6'b0111??: bts = 1'b1;
      6'b100???: begin push = 1'b1; ld = 1'b1; fl = 1'b1; end
      6'b101???: begin ld = 1'b1; fl = 1'b1; end
      6'b1100??: begin op = OP_PLF; ls = 1'b1; wr = 1'b1; end
      6'b1101??: begin op = OP_PLF; ls = 1'b1; wr = 1'b1; pop = 1'b1; fl = 1'b1; end
      6'b111000: begin op = OP_IOR; ls = 1'b1; wr = 1'b1; st = 1'b1; end
      6'b111001: begin op = OP_AND; ls = 1'b1; wr = 1'b1; st = 1'b1; end
      6'b111010: begin op = OP_XOR; ls = 1'b1; wr = 1'b1; st = 1'b1; end
      6'b11110?: begin op = OP_SUB; ls = 1'b1; wr = 1'b1; st = 1'b1; end
      6'b11111?: begin op = OP_ADD; ls = 1'b1; wr = 1'b1; st = 1'b1; end
      default:   ill = 1'b1;
    endcase
    if (bw) begin
      d = ir_q[7];
      wr = 1'b1;
    end
  end
  assign q4      = q_q == Q4;
  assign q_d     = q_q + 2'd1;
  assign ir_d    = (q_q == Q1) ? (flush_q ? 14'h0000 : instr_in) : ir_q;
  assign flush_d = (q_q == Q1) ? 1'b0 :
                   (q4 && (fl || (skz && alu_out_z) || (btc && !alu_bit_test_res) || (bts && alu_bit_test_res))) ? 1'b1 :
                   flush_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q     <= Q1;
      ir_q    <= 14'h0000;
      flush_q <= 1'b1;
    end else begin
      q_q     <= q_d;
      ir_q    <= ir_d;
      flush_q <= flush_d;
    end
  end
  assign q_phase          = q_q;
  assign ir               = ir_q;
  assign alu_op           = op;
  assign alu_d            = d;
  assign lit_sel          = ls;
  assign literal          = ir_q[7:0];
  assign f_addr           = ir_q[FADDR_W-1:0];
  assign bit_sel          = ir_q[9:7];
  assign pc_load_val      = ir_q[PC_W-1:0];
  assign alu_d_wr_en      = q4 && wr;
  assign alu_status_wr_en = q4 && st;
  assign bit_set_en       = q4 && bset;
  assign bit_clr_en       = q4 && bclr;
  assign pc_load          = q4 && ld;
  assign stack_push       = q4 && push;
  assign stack_pop        = q4 && pop;
  assign illegal_instr    = q4 && ill;
  assign pc_inc           = rst_n && q_q == Q1;
endmodule
